// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA types, AXI-Lite configuration register offsets and response codes.
// Rev 1.0 - initial release.
`default_nettype none

package vga_pkg;

  typedef enum logic {
    VGA_RES_800_600   = 1'b0,
    VGA_RES_1280_1024 = 1'b1
  } vga_resolution_e;

  localparam logic [31:0] VGA_CFG_CTRL_ADDR    = 32'h0000_0000;
  localparam logic [31:0] VGA_CFG_STATUS_ADDR  = 32'h0000_0004;
  localparam logic [31:0] VGA_CFG_SCRATCH_ADDR = 32'h0000_0008;
  localparam logic [31:0] VGA_CFG_IRQ_EN_ADDR  = 32'h0000_000C;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Byte-lane merge of a write into a 32-bit register.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axil_cfg_slave_if.sv
// vga_axil_cfg_slave_if: AXI4-Lite bus bundle with master and slave views.
// Rev 1.0 - initial release.
`default_nettype none

interface vga_axil_cfg_slave_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/vga_axil_cfg_slave_axil_slave_if.sv
// axil_slave_if: AXI4-Lite handshake engine exposing a word-addressed register port.
// Rev 1.0 - initial release.
`default_nettype none

module axil_slave_if
  import vga_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  vga_axil_cfg_slave_if.slave s_axi,
  output logic                o_wr_en,
  output logic [ADDR_W-3:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_strb,
  input  logic                i_wr_err,
  output logic                o_rd_en,
  output logic [ADDR_W-3:0]   o_rd_addr,
  input  logic [DATA_W-1:0]   i_rd_data,
  input  logic                i_rd_err
);

  logic                r_live;
  logic                r_aw_held;
  logic                r_w_held;
  logic [ADDR_W-3:0]   r_aw_addr;
  logic [DATA_W-1:0]   r_w_data;
  logic [DATA_W/8-1:0] r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic                w_aw_fire;
  logic                w_w_fire;
  logic                w_unused;

  // r_live keeps every ready low while reset is applied and for the first cycle after.
  assign s_axi.s_axi_awready = r_live & ~r_aw_held;
  assign s_axi.s_axi_wready  = r_live & ~r_w_held;
  assign s_axi.s_axi_arready = r_live & ~r_rvalid;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;

  assign w_aw_fire = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
  assign w_w_fire  = s_axi.s_axi_wvalid & s_axi.s_axi_wready;

  assign o_wr_en   = r_aw_held & r_w_held & ~r_bvalid;
  assign o_wr_addr = r_aw_addr;
  assign o_wr_data = r_w_data;
  assign o_wr_strb = r_w_strb;

  assign o_rd_en   = s_axi.s_axi_arvalid & s_axi.s_axi_arready;
  assign o_rd_addr = s_axi.s_axi_araddr[ADDR_W-1:2];

  assign w_unused = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= AXI_RESP_OKAY;
    end else begin
      r_live <= 1'b1;

      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi.s_axi_awaddr[ADDR_W-1:2];
      end else if (o_wr_en) begin
        r_aw_held <= 1'b0;
      end

      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi.s_axi_wdata;
        r_w_strb <= s_axi.s_axi_wstrb;
      end else if (o_wr_en) begin
        r_w_held <= 1'b0;
      end

      if (o_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= i_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (s_axi.s_axi_bready) begin
        r_bvalid <= 1'b0;
      end

      if (o_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= i_rd_data;
        r_rresp  <= i_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (s_axi.s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_axil_cfg_slave.sv
// vga_axil_cfg_slave: AXI4-Lite register block driving the VGA clock generator's resolution/request.
// Optional IRQ output and IRQ_EN register when VGA_AXIL_CFG_IRQ_EN is defined. Rev 1.0 - initial release.
`default_nettype none

module vga_axil_cfg_slave
  import vga_pkg::*;
#(
  parameter int          ADDR_W      = 11,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input  logic                clk_100m_i,
  input  logic                rst_i,
  vga_axil_cfg_slave_if.slave s_axi,
  output vga_resolution_e     resolution_o,
  output logic                req_o,
  input  logic                valid_i
`ifdef VGA_AXIL_CFG_IRQ_EN
  ,
  output logic                irq_o
`endif
);

  localparam logic [ADDR_W-3:0] c_ctrl_wa    = VGA_CFG_CTRL_ADDR[ADDR_W-1:2];
  localparam logic [ADDR_W-3:0] c_status_wa  = VGA_CFG_STATUS_ADDR[ADDR_W-1:2];
  localparam logic [ADDR_W-3:0] c_scratch_wa = VGA_CFG_SCRATCH_ADDR[ADDR_W-1:2];
`ifdef VGA_AXIL_CFG_IRQ_EN
  localparam logic [ADDR_W-3:0] c_irq_en_wa  = VGA_CFG_IRQ_EN_ADDR[ADDR_W-1:2];
`endif

  logic                w_wr_en;
  logic [ADDR_W-3:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W/8-1:0] w_wr_strb;
  logic                w_wr_err;
  logic                w_rd_en;
  logic [ADDR_W-3:0]   w_rd_addr;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_rd_err;
  logic                w_ctrl_we;
  logic                w_done_w1c;
  logic                w_scratch_we;
  logic                w_irq_en_we;

  vga_resolution_e     r_res;
  logic                r_req;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_scratch;
`ifdef VGA_AXIL_CFG_IRQ_EN
  logic                r_irq_en;
  logic                r_irq;
`endif

  axil_slave_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_axil (
    .clk       (clk_100m_i),
    .rst       (rst_i),
    .s_axi     (s_axi),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err),
    .o_rd_en   (w_rd_en),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data),
    .i_rd_err  (w_rd_err)
  );

  // CTRL is locked while BUSY so resolution_o cannot move under the generator.
  always_comb begin
    w_wr_err     = 1'b0;
    w_ctrl_we    = 1'b0;
    w_done_w1c   = 1'b0;
    w_scratch_we = 1'b0;
    w_irq_en_we  = 1'b0;
    case (w_wr_addr)
      c_ctrl_wa: begin
        if (r_busy) w_wr_err  = 1'b1;
        else        w_ctrl_we = w_wr_strb[0];
      end
      c_status_wa:  w_done_w1c   = w_wr_strb[0] & w_wr_data[1];
      c_scratch_wa: w_scratch_we = 1'b1;
`ifdef VGA_AXIL_CFG_IRQ_EN
      c_irq_en_wa:  w_irq_en_we  = w_wr_strb[0];
`endif
      default:      w_wr_err     = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_rd_addr)
      c_ctrl_wa:    w_rd_data[0]   = r_res;
      c_status_wa:  w_rd_data[1:0] = {r_done, r_busy};
      c_scratch_wa: w_rd_data      = r_scratch;
`ifdef VGA_AXIL_CFG_IRQ_EN
      c_irq_en_wa:  w_rd_data[0]   = r_irq_en;
`endif
      default:      w_rd_err       = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100m_i) begin
    if (rst_i) begin
      r_res     <= VGA_RES_800_600;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_scratch <= SCRATCH_RST;
`ifdef VGA_AXIL_CFG_IRQ_EN
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
`endif
    end else begin
      r_req <= 1'b0;
      if (w_wr_en && w_ctrl_we) begin
        r_res <= vga_resolution_e'(w_wr_data[0]);
        r_req <= w_wr_data[1];
        if (w_wr_data[1]) r_busy <= 1'b1;
      end else if (valid_i && r_busy) begin
        r_busy <= 1'b0;
      end

      // A completion pulse beats a same-cycle W1C of DONE.
      if (valid_i)                      r_done <= 1'b1;
      else if (w_wr_en && w_done_w1c)   r_done <= 1'b0;

      if (w_wr_en && w_scratch_we)
        r_scratch <= apply_strb(r_scratch, w_wr_data, w_wr_strb);
`ifdef VGA_AXIL_CFG_IRQ_EN
      if (w_wr_en && w_irq_en_we) r_irq_en <= w_wr_data[0];
      r_irq <= r_done & r_irq_en;
`endif
    end
  end

  assign resolution_o = r_res;
  assign req_o        = r_req;
`ifdef VGA_AXIL_CFG_IRQ_EN
  assign irq_o        = r_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = w_irq_en_we;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_axil_cfg_slave.sv
// tb_vga_axil_cfg_slave: directed and randomized checks of the VGA AXI-Lite config slave.
`default_nettype none
`timescale 1ns/1ps

module tb_vga_axil_cfg_slave;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic valid_i;
  logic req_o;
  vga_resolution_e resolution_o;
`ifdef VGA_AXIL_CFG_IRQ_EN
  logic irq_o;
`endif

  always #5 clk = ~clk;

  vga_axil_cfg_slave_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  vga_axil_cfg_slave #(.ADDR_W(11), .DATA_W(32), .SCRATCH_RST(32'h0)) dut (
    .clk_100m_i   (clk),
    .rst_i        (rst),
    .s_axi        (bus),
    .resolution_o (resolution_o),
    .req_o        (req_o),
    .valid_i      (valid_i)
`ifdef VGA_AXIL_CFG_IRQ_EN
    ,
    .irq_o        (irq_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  always @(negedge clk) if (req_o === 1'b1) req_cnt++;

  // Reference model state: register contents as the host sees them.
  logic       m_res, m_busy, m_done, m_irq_en;
  logic [31:0] m_scratch;
  int         m_req_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    m_res = 0; m_busy = 0; m_done = 0; m_irq_en = 0; m_scratch = 32'h0;
  endfunction

  function automatic logic [1:0] mdl_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a >> 2)
      0: begin
        if (m_busy) return 2'b10;
        if (s[0]) begin
          m_res = d[0];
          if (d[1]) begin m_busy = 1; m_req_cnt++; end
        end
        return 2'b00;
      end
      1: begin if (s[0] && d[1]) m_done = 0; return 2'b00; end
      2: begin
        for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
        return 2'b00;
      end
`ifdef VGA_AXIL_CFG_IRQ_EN
      3: begin if (s[0]) m_irq_en = d[0]; return 2'b00; end
`endif
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [33:0] mdl_read(input logic [10:0] a);
    case (a >> 2)
      0: return {2'b00, 31'h0, m_res};
      1: return {2'b00, 30'h0, m_done, m_busy};
      2: return {2'b00, m_scratch};
`ifdef VGA_AXIL_CFG_IRQ_EN
      3: return {2'b00, 31'h0, m_irq_en};
`endif
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  function automatic void mdl_valid();
    m_busy = 0;
    m_done = 1;
  endfunction

  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_d, input int w_d, input int b_d,
                           output logic [1:0] resp, output int lat, output bit w_drop, output bit b_stable);
    int cyc = 0, fire_cyc = 0, hold = 0, bw = 0;
    bit aw_done = 0, w_done = 0, aw_f = 0, w_f = 0, got = 0;
    resp = 2'bxx; lat = -1; w_drop = 0; b_stable = 1;
    bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
    while (1) begin
      @(negedge clk); cyc++;
      if (aw_f) aw_done = 1;
      if (w_f)  w_done = 1;
      bus.s_axi_awvalid = !aw_done && cyc > aw_d;
      bus.s_axi_wvalid  = !w_done && cyc > w_d;
      if (aw_done && w_done) break;
      if (w_done && !aw_done && bus.s_axi_wready !== 1'b0) w_drop = 0;
      else if (w_done && !aw_done) w_drop = 1;
      aw_f = bus.s_axi_awvalid && bus.s_axi_awready;
      w_f  = bus.s_axi_wvalid && bus.s_axi_wready;
      if (cyc > 200) break;
    end
    fire_cyc = cyc - 1;
    while (bw < 200) begin
      if (bus.s_axi_bvalid === 1'b1) begin
        if (lat < 0) begin lat = cyc - fire_cyc - 1; resp = bus.s_axi_bresp; end
        else if (bus.s_axi_bresp !== resp) b_stable = 0;
        if (hold >= b_d) begin
          bus.s_axi_bready = 1;
          @(negedge clk);
          bus.s_axi_bready = 0;
          got = 1;
          break;
        end
        hold++;
      end else if (lat >= 0) b_stable = 0;
      @(negedge clk); cyc++; bw++;
    end
    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
    if (!got) check("wr_timeout", 32'(got), 32'h1);
  endtask

  task automatic axi_read(input logic [10:0] a, input int r_d, output logic [31:0] d, output logic [1:0] resp);
    int cyc = 0;
    bit fired = 0;
    @(negedge clk);
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1;
    while (!fired && cyc < 200) begin
      if (bus.s_axi_arready === 1'b1) fired = 1;
      @(negedge clk); cyc++;
    end
    bus.s_axi_arvalid = 0;
    while (bus.s_axi_rvalid !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    if (bus.s_axi_rvalid !== 1'b1) check("rd_timeout", 32'(bus.s_axi_rvalid), 32'h1);
    repeat (r_d) @(negedge clk);
    d = bus.s_axi_rdata; resp = bus.s_axi_rresp;
    bus.s_axi_rready = 1;
    @(negedge clk);
    bus.s_axi_rready = 0;
  endtask

  task automatic pulse_valid();
    @(negedge clk); valid_i = 1;
    @(negedge clk); valid_i = 0;
    mdl_valid();
  endtask

  logic [1:0]  resp, rresp, eresp;
  logic [31:0] rdata;
  logic [33:0] exp_rd;
  int          lat;
  bit          wdrop, bstab;

  task automatic rd_chk(input string tag, input logic [10:0] a);
    logic [31:0] dd;
    logic [1:0]  rr;
    logic [33:0] e;
    e = mdl_read(a);
    axi_read(a, $urandom_range(0, 2), dd, rr);
    check({tag, "_rdata"}, dd, e[31:0]);
    check({tag, "_rresp"}, 32'(rr), 32'(e[33:32]));
  endtask

  task automatic wr_chk(input string tag, input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] rr, e;
    int l;
    bit wd, bs;
    e = mdl_write(a, d, s);
    axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rr, l, wd, bs);
    check({tag, "_bresp"}, 32'(rr), 32'(e));
    check({tag, "_bstable"}, 32'(bs), 32'h1);
  endtask

  initial begin
    rst = 1; valid_i = 1;
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_wvalid = 0; bus.s_axi_bready = 0; bus.s_axi_araddr = '0; bus.s_axi_arvalid = 0;
    bus.s_axi_rready = 0;
    mdl_reset();
    repeat (2) @(negedge clk);
    check("rst_awready", 32'(bus.s_axi_awready), 32'h0);
    check("rst_wready", 32'(bus.s_axi_wready), 32'h0);
    check("rst_arready", 32'(bus.s_axi_arready), 32'h0);
    check("rst_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
    check("rst_rvalid", 32'(bus.s_axi_rvalid), 32'h0);
    check("rst_req", 32'(req_o), 32'h0);
    check("rst_res", 32'(resolution_o), 32'(VGA_RES_800_600));
    rst = 0; valid_i = 0;
    repeat (2) @(negedge clk);
    rd_chk("rst_status", 11'h004);

    // Test 1: start a reconfiguration to 1280x1024.
    eresp = mdl_write(11'h000, 32'h3, 4'hF);
    axi_write(11'h000, 32'h3, 4'hF, 0, 0, 0, resp, lat, wdrop, bstab);
    check("t1_bresp", 32'(resp), 32'(eresp));
    check("t1_latency", 32'(lat), 32'h1);
    check("t1_res", 32'(resolution_o), 32'(VGA_RES_1280_1024));
    repeat (3) @(negedge clk);
    check("t1_req_pulses", 32'(req_cnt), 32'(m_req_cnt));
    rd_chk("t1_status", 11'h004);

    // Test 2: W leads AW, B back-pressured.
    eresp = mdl_write(11'h008, 32'hDEADBEEF, 4'hF);
    axi_write(11'h008, 32'hDEADBEEF, 4'hF, 3, 0, 4, resp, lat, wdrop, bstab);
    check("t2_bresp", 32'(resp), 32'(eresp));
    check("t2_wready_drop", 32'(wdrop), 32'h1);
    check("t2_bstable", 32'(bstab), 32'h1);
    rd_chk("t2_scratch", 11'h008);

    // Test 3: CTRL locked while busy, DONE set and W1C.
    wr_chk("t3_ctrl_busy", 11'h000, 32'h2, 4'hF);
    check("t3_res", 32'(resolution_o), 32'(VGA_RES_1280_1024));
    repeat (2) @(negedge clk);
    check("t3_req_pulses", 32'(req_cnt), 32'(m_req_cnt));
    pulse_valid();
    rd_chk("t3_status_done", 11'h004);
    wr_chk("t3_w1c", 11'h004, 32'h2, 4'h1);
    rd_chk("t3_status_clr", 11'h004);
    // W1C commit coinciding with valid_i: DONE must stay set.
    eresp = mdl_write(11'h004, 32'h2, 4'h1);
    fork
      axi_write(11'h004, 32'h2, 4'h1, 0, 0, 0, resp, lat, wdrop, bstab);
      begin
        @(negedge clk); @(negedge clk); valid_i = 1;
        @(negedge clk); valid_i = 0;
      end
    join
    mdl_valid();
    check("t3_setwins_bresp", 32'(resp), 32'(eresp));
    rd_chk("t3_setwins", 11'h004);

    // Test 4: unmapped address, concurrent read during pending write.
    rd_chk("t4_bad_rd", 11'h100);
    wr_chk("t4_bad_wr", 11'h100, 32'h1234_5678, 4'hF);
    exp_rd = mdl_read(11'h008);
    eresp = mdl_write(11'h004, 32'h0, 4'hF);
    fork
      axi_write(11'h004, 32'h0, 4'hF, 0, 1, 6, resp, lat, wdrop, bstab);
      begin repeat (2) @(negedge clk); axi_read(11'h008, 1, rdata, rresp); end
    join
    check("t4_conc_bresp", 32'(resp), 32'(eresp));
    check("t4_conc_rdata", rdata, exp_rd[31:0]);
    check("t4_conc_rresp", 32'(rresp), 32'(exp_rd[33:32]));

    // Test 5: reset with a held AW and a pending B.
    wr_chk("t5_ctrl", 11'h000, 32'h1, 4'hF);
    @(negedge clk);
    bus.s_axi_awaddr = 11'h008; bus.s_axi_awvalid = 1; bus.s_axi_wdata = 32'h5555_AAAA;
    bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1;
    @(negedge clk); bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
    repeat (2) @(negedge clk);
    check("t5_bpending", 32'(bus.s_axi_bvalid), 32'h1);
    bus.s_axi_awaddr = 11'h000; bus.s_axi_awvalid = 1;
    @(negedge clk); bus.s_axi_awvalid = 0; rst = 1;
    @(negedge clk); rst = 0;
    mdl_reset();
    check("t5_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
    check("t5_rvalid", 32'(bus.s_axi_rvalid), 32'h0);
    check("t5_res", 32'(resolution_o), 32'(VGA_RES_800_600));
    repeat (2) @(negedge clk);
    check("t5_aw_free", 32'(bus.s_axi_awready), 32'h1);
    rd_chk("t5_scratch", 11'h008);
    rd_chk("t5_status", 11'h004);

`ifdef VGA_AXIL_CFG_IRQ_EN
    // Test 6: interrupt follows DONE by one cycle.
    wr_chk("t6_irqen", 11'h00C, 32'h1, 4'hF);
    wr_chk("t6_start", 11'h000, 32'h2, 4'hF);
    check("t6_irq_idle", 32'(irq_o), 32'h0);
    pulse_valid();
    check("t6_irq_lag", 32'(irq_o), 32'h0);
    @(negedge clk);
    check("t6_irq_set", 32'(irq_o), 32'h1);
    wr_chk("t6_w1c", 11'h004, 32'h2, 4'h1);
    repeat (2) @(negedge clk);
    check("t6_irq_clr", 32'(irq_o), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      logic [10:0] a;
      logic [31:0] d;
      int op, sel;
      sel = $urandom_range(0, 6);
      case (sel)
        0: a = 11'h000; 1: a = 11'h004; 2: a = 11'h008; 3: a = 11'h00C;
        4: a = 11'h010; 5: a = 11'h100; default: a = 11'h7FC;
      endcase
      a = a | 11'($urandom_range(0, 3));
      d = $urandom;
      op = $urandom_range(0, 9);
      if (op <= 3)      wr_chk("rnd_wr", a, d, 4'($urandom_range(0, 15)));
      else if (op <= 6) rd_chk("rnd_rd", a);
      else if (op == 7) pulse_valid();
      else              repeat ($urandom_range(1, 3)) @(negedge clk);
      repeat (2) @(negedge clk);
      check("rnd_res", 32'(resolution_o), 32'(m_res));
      check("rnd_req_pulses", 32'(req_cnt), 32'(m_req_cnt));
`ifdef VGA_AXIL_CFG_IRQ_EN
      check("rnd_irq", 32'(irq_o), 32'(m_done & m_irq_en));
`endif
    end
    rd_chk("end_status", 11'h004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/vga_axil_cfg_slave.md
Name: vga_axil_cfg_slave

Overview:
- AXI4-Lite responder (slave) that exposes the VGA clock/mode configuration to a host (MicroBlaze/JTAG-AXI).
- Holds the resolution selection and issues a one-cycle reconfiguration request towards the clock generator. It then tracks busy/done until the generator reports valid.
- Sits between the host interconnect and the VGA clock generator's resolution/request/valid interface.
- AXI protocol counterpart of the generator's own AXI-Lite initiator logic.

Parameters:
- ADDR_W, 11, AXI address width, matching the clocking-wizard map.
- DATA_W, 32, AXI data width. Only 32 is supported.
- SCRATCH_RST, 32'h0, reset value of the SCRATCH register.

Ports:
- clk_100m_i  in  1  system clock. All logic is on this clock.
- rst_i  in  1  reset. Synchronous, active-high.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_W  write data.
- s_axi_wstrb  in  DATA_W/8  write byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response: OKAY=2'b00, SLVERR=2'b10.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_W  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- resolution_o  out  vga_resolution_e  selected resolution to the clock generator.
- req_o  out  1  single-cycle reconfiguration request.
- valid_i  in  1  single-cycle completion pulse from the clock generator.

Behaviour:
Reset (rst_i high at a clock edge):
- All ready/valid outputs are 0, bresp/rresp/rdata are 0 and req_o is 0.
- resolution_o is VGA_RES_800_600, busy=0, done=0, SCRATCH=SCRATCH_RST.
- Any AXI transaction in flight is discarded. A valid_i pulse arriving in the reset cycle is ignored.

Register map (word aligned; address bits [1:0] are ignored):
- 0x000 CTRL, RW.
  - bit0 RES: 0 selects 800x600, 1 selects 1280x1024.
  - bit1 START: write-1 pulses req_o; always reads 0.
- 0x004 STATUS.
  - bit0 BUSY, RO.
  - bit1 DONE, W1C.
- 0x008 SCRATCH, RW, with full byte-strobe support.
- Any other address gives SLVERR. Writes to it have no effect; reads return 0.

Write channel:
- AW and W are accepted independently. awready = !aw_held, wready = !w_held, and each is captured into a holding register.
- The register update happens in the first cycle where aw_held && w_held && !bvalid.
  - In that cycle bvalid rises with its bresp, and both holds clear.
- bvalid and bresp stay stable until bready. No new write commits while bvalid=1.
- Strobes: CTRL and STATUS bits use wstrb[0]. If wstrb[0]=0, CTRL and STATUS are unchanged and the response is OKAY.

Read channel:
- arready = !rvalid. An accepted AR gives rvalid in the next cycle, with rdata/rresp registered and held until rready.
- Read and write channels are fully concurrent.

Control behaviour:
- A CTRL write while BUSY=1 returns SLVERR and changes neither RES nor req_o, so resolution_o stays stable during reconfiguration.
- A CTRL write with BUSY=0:
  - RES updates in the commit cycle.
  - If START=1, req_o=1 in the cycle after commit for exactly 1 cycle, and BUSY sets in that same cycle.
- valid_i while BUSY=1 clears BUSY and sets DONE. valid_i while BUSY=0 sets DONE only.
- DONE W1C in the same cycle as valid_i: set wins.
- Re-entry: a START write is accepted on the commit cycle after BUSY clears.

Optional Feature:
- Macro: VGA_AXIL_CFG_IRQ_EN.
- Defined: adds output irq_o (1 bit) and register 0x00C IRQ_EN (RW, bit0).
  - irq_o = DONE && IRQ_EN, registered, with reset value 0.
- Not defined: no irq_o port, and address 0x00C returns SLVERR.

Decomposition:
Shared package vga_pkg holds:
- Register offsets: VGA_CFG_CTRL_ADDR, VGA_CFG_STATUS_ADDR, VGA_CFG_SCRATCH_ADDR, VGA_CFG_IRQ_EN_ADDR.
- Response codes: AXI_RESP_OKAY, AXI_RESP_SLVERR.
- The existing vga_resolution_e.

One sub-module is natural: axil_slave_if. It holds the AW/W capture, B/AR/R handshake and a generic wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data/rd_err interface. The register decode lives in vga_axil_cfg_slave.

Test Plan:
1. Write 0x000=32'h3 with AW and W in the same cycle, bready=1. Expect bresp=OKAY one cycle after acceptance, resolution_o=VGA_RES_1280_1024, and req_o high for exactly 1 cycle. Read 0x004 returns 32'h1.
2. W presented 3 cycles before AW, with bready held low for 4 cycles. Expect wready to drop after capture, bvalid held steady, and no second commit until the B handshake. SCRATCH=32'hDEADBEEF reads back exactly.
3. With BUSY=1, write 0x000=32'h2. Expect SLVERR, no req_o, and resolution_o unchanged. Then pulse valid_i: read 0x004 returns 32'h2. Write 0x004=32'h2 and expect a read of 32'h0.
4. Read 0x100 and write 0x100. Expect rresp=SLVERR with rdata=0, and bresp=SLVERR. Issue a concurrent read of 0x008 during a pending write. Both complete, each with correct data.
5. Assert rst_i mid-transaction, with AW held and bvalid pending. Expect all valids=0, resolution_o=VGA_RES_800_600 and SCRATCH=SCRATCH_RST on the next cycle.
6. With VGA_AXIL_CFG_IRQ_EN defined, set IRQ_EN=1, START, then valid_i. Expect irq_o=1 the cycle after DONE sets, and 0 after the W1C.
